// File: rtl/leiwand_rv32_mem_arbiter_if.sv
// Memory bus bundle shared by the core, the loader/debug DMA master and
// simple_mem. A requester drives valid/addr/wdata/wen and holds valid until it
// sees the ready pulse; the responder answers with ready, plus rdata and err
// qualified by that same ready cycle.
interface leiwand_rv32_mem_arbiter_if #(
   parameter int XLEN = 32
);
   logic            valid;
   logic [XLEN-1:0] addr;
   logic [XLEN-1:0] wdata;
   logic [3:0]      wen;
   logic            ready;
   logic [XLEN-1:0] rdata;
   logic            err;

   // Side that issues requests (a CPU/DMA master, or the arbiter towards memory)
   modport master (
      output valid, addr, wdata, wen,
      input  ready, rdata, err
   );

   // Side that answers requests (memory, or the arbiter towards each master)
   modport slave (
      input  valid, addr, wdata, wen,
      output ready, rdata, err
   );
endinterface

// File: rtl/leiwand_rv32_mem_arbiter.sv
// Two-master / one-slave memory arbiter. Round-robin grant held for a whole
// transaction, a guaranteed valid-low DONE cycle between transactions, and a
// watchdog that completes a stalled transaction with an error response.
//
// Handshake: a master raises valid with a stable request and keeps it high
// until ready; ready is a single-cycle completion pulse, and rdata/err are only
// meaningful while ready is high (they read 0 otherwise). Dropping valid before
// ready aborts the request with no response.
module leiwand_rv32_mem_arbiter #(
   parameter int          XLEN           = 32,
   parameter int          TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_DATA       = 32'hDEADBEEF
) (
   input  logic                              clk,
   input  logic                              reset_n,
   leiwand_rv32_mem_arbiter_if.slave         m0,
   leiwand_rv32_mem_arbiter_if.slave         m1,
   leiwand_rv32_mem_arbiter_if.master        s,
   output logic [1:0]                        o_dbg_state
);

   localparam int              CW          = $clog2(TIMEOUT_CYCLES);
   localparam logic [CW-1:0]   LP_CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [XLEN-1:0] LP_ERR_DATA = XLEN'(ERR_DATA);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_grant;       // 0 = master 0, 1 = master 1
   logic            r_last_grant;  // master that completed most recently
   logic [CW-1:0]   r_cnt;

   state_t          w_nxt_state;
   logic            w_nxt_grant;
   logic            w_nxt_last;
   logic [CW-1:0]   w_nxt_cnt;

   logic            w_gnt_valid;
   logic [XLEN-1:0] w_gnt_addr;
   logic [XLEN-1:0] w_gnt_wdata;
   logic [3:0]      w_gnt_wen;

   logic            w_s_valid;
   logic [XLEN-1:0] w_s_addr;
   logic [XLEN-1:0] w_s_wdata;
   logic [3:0]      w_s_wen;
   logic            w_rsp_ready;
   logic [XLEN-1:0] w_rsp_rdata;
   logic            w_rsp_err;

   // Request of the currently granted master
   assign w_gnt_valid = r_grant ? m1.valid : m0.valid;
   assign w_gnt_addr  = r_grant ? m1.addr  : m0.addr;
   assign w_gnt_wdata = r_grant ? m1.wdata : m0.wdata;
   assign w_gnt_wen   = r_grant ? m1.wen   : m0.wen;

   // State, grant and watchdog registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_grant      <= 1'b0;
         r_last_grant <= 1'b1;
         r_cnt        <= '0;
      end else begin
         r_state      <= w_nxt_state;
         r_grant      <= w_nxt_grant;
         r_last_grant <= w_nxt_last;
         r_cnt        <= w_nxt_cnt;
      end
   end

   // Arbitration, transaction tracking and bus outputs
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_grant = r_grant;
      w_nxt_last  = r_last_grant;
      w_nxt_cnt   = r_cnt;
      w_s_valid   = 1'b0;
      w_s_addr    = '0;
      w_s_wdata   = '0;
      w_s_wen     = '0;
      w_rsp_ready = 1'b0;
      w_rsp_rdata = '0;
      w_rsp_err   = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (m0.valid || m1.valid) begin
               // On a tie the master that did not finish last wins
               w_nxt_grant = (m0.valid && m1.valid) ? ~r_last_grant : m1.valid;
               w_nxt_cnt   = '0;
               w_nxt_state = ST_BUSY;
            end
         end

         ST_BUSY: begin
            w_s_addr  = w_gnt_addr;
            w_s_wdata = w_gnt_wdata;
            w_s_wen   = w_gnt_wen;
            if (!w_gnt_valid) begin
               // Master withdrew: no response, fairness history untouched
               w_nxt_state = ST_IDLE;
            end else if (s.ready) begin
               w_s_valid   = 1'b1;
               w_rsp_ready = 1'b1;
               w_rsp_rdata = s.rdata;
               w_nxt_last  = r_grant;
               w_nxt_state = ST_DONE;
            end else if (r_cnt == LP_CNT_LAST) begin
               // Watchdog expired: withdraw from the slave, answer with error
               w_rsp_ready = 1'b1;
               w_rsp_rdata = LP_ERR_DATA;
               w_rsp_err   = 1'b1;
               w_nxt_last  = r_grant;
               w_nxt_state = ST_DONE;
            end else begin
               w_s_valid = 1'b1;
               w_nxt_cnt = r_cnt + CW'(1);
            end
         end

         ST_DONE: begin
            w_nxt_state = ST_IDLE;
         end

         default: begin
            w_nxt_state = ST_IDLE;
         end
      endcase
   end

   assign s.valid  = w_s_valid;
   assign s.addr   = w_s_addr;
   assign s.wdata  = w_s_wdata;
   assign s.wen    = w_s_wen;

   assign m0.ready = w_rsp_ready & ~r_grant;
   assign m0.rdata = r_grant ? '0 : w_rsp_rdata;
   assign m0.err   = w_rsp_err & ~r_grant;
   assign m1.ready = w_rsp_ready & r_grant;
   assign m1.rdata = r_grant ? w_rsp_rdata : '0;
   assign m1.err   = w_rsp_err & r_grant;

   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_leiwand_rv32_mem_arbiter.sv
// Directed bench for leiwand_rv32_mem_arbiter: the main process drives the
// masters and a scripted slave and pushes expected responses; a negedge
// monitor pops and compares every master response it sees.
module tb_leiwand_rv32_mem_arbiter;

   localparam int XLEN = 32;

   logic clk;
   logic reset_n;
   logic [1:0] dbg_state;

   logic            slave_echo;
   logic [XLEN-1:0] slave_rdata;

   int n_checks;
   int n_errors;

   // {master, rdata, err}
   logic [33:0] exp_q[$];

   leiwand_rv32_mem_arbiter_if #(.XLEN(XLEN)) m0_if ();
   leiwand_rv32_mem_arbiter_if #(.XLEN(XLEN)) m1_if ();
   leiwand_rv32_mem_arbiter_if #(.XLEN(XLEN)) s_if ();

   assign s_if.err   = 1'b0;
   assign s_if.rdata = slave_echo ? ~s_if.addr : slave_rdata;

   leiwand_rv32_mem_arbiter #(
      .XLEN(XLEN),
      .TIMEOUT_CYCLES(8),
      .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .m0(m0_if),
      .m1(m1_if),
      .s(s_if),
      .o_dbg_state(dbg_state)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_m(input int mst, input logic v, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] w);
      if (mst == 0) begin
         m0_if.valid = v; m0_if.addr = a; m0_if.wdata = d; m0_if.wen = w;
      end else begin
         m1_if.valid = v; m1_if.addr = a; m1_if.wdata = d; m1_if.wen = w;
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   function automatic logic [33:0] mk_exp(input logic mst, input logic [31:0] rd, input logic e);
      return {mst, rd, e};
   endfunction

   // monitor / scoreboard
   always @(negedge clk) begin
      logic [33:0] e;
      if (m0_if.ready && m1_if.ready) begin
         chk("both_ready", 32'd1, 32'd0);
      end else if (m0_if.ready || m1_if.ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_ready", {31'd0, m1_if.ready}, 32'hFFFFFFFF);
         end else begin
            e = exp_q.pop_front();
            chk("rsp_master", {31'd0, m1_if.ready}, {31'd0, e[33]});
            if (m1_if.ready) begin
               chk("rsp_rdata", m1_if.rdata, e[32:1]);
               chk("rsp_err", {31'd0, m1_if.err}, {31'd0, e[0]});
               chk("idle_m0_rdata", m0_if.rdata | {31'd0, m0_if.err}, 32'd0);
            end else begin
               chk("rsp_rdata", m0_if.rdata, e[32:1]);
               chk("rsp_err", {31'd0, m0_if.err}, {31'd0, e[0]});
               chk("idle_m1_rdata", m1_if.rdata | {31'd0, m1_if.err}, 32'd0);
            end
         end
      end else begin
         chk("quiet_rdata", m0_if.rdata | m1_if.rdata, 32'd0);
         chk("quiet_err", {30'd0, m0_if.err, m1_if.err}, 32'd0);
      end
   end

   // stimulus
   initial begin
      n_checks    = 0;
      n_errors    = 0;
      reset_n     = 1'b0;
      slave_echo  = 1'b0;
      slave_rdata = '0;
      s_if.ready  = 1'b0;
      drive_m(0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive_m(1, 1'b0, 32'd0, 32'd0, 4'd0);

      // reset state
      @(negedge clk);
      chk("rst_s_valid", {31'd0, s_if.valid}, 32'd0);
      chk("rst_s_addr", s_if.addr, 32'd0);
      chk("rst_s_wen", {28'd0, s_if.wen}, 32'd0);
      chk("rst_state", {30'd0, dbg_state}, 32'd0);
      do_reset();

      // single read by m0, slave answers in the second BUSY cycle
      drive_m(0, 1'b1, 32'h80000000, 32'd0, 4'd0);
      @(negedge clk);
      chk("rd_arb_latency", {31'd0, s_if.valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("rd_s_valid", {31'd0, s_if.valid}, 32'd1);
      chk("rd_s_addr", s_if.addr, 32'h80000000);
      chk("rd_s_wen", {28'd0, s_if.wen}, 32'd0);
      tick();
      slave_rdata = 32'h00000297;
      exp_q.push_back(mk_exp(1'b0, 32'h00000297, 1'b0));
      s_if.ready = 1'b1;
      @(negedge clk);
      tick();
      s_if.ready = 1'b0;
      drive_m(0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      chk("rd_done_s_valid", {31'd0, s_if.valid}, 32'd0);
      chk("rd_done_state", {30'd0, dbg_state}, 32'd2);
      tick();

      // contention from reset release, zero-wait slave
      reset_n    = 1'b0;
      slave_echo = 1'b1;
      s_if.ready = 1'b1;
      drive_m(0, 1'b1, 32'h00000100, 32'd0, 4'd0);
      drive_m(1, 1'b1, 32'h00000200, 32'd0, 4'd0);
      for (int k = 0; k < 4; k++)
         exp_q.push_back(mk_exp(k[0], ~((k % 2 == 0) ? 32'h00000100 : 32'h00000200), 1'b0));
      do_reset();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("ct_idle_s_valid", {31'd0, s_if.valid}, 32'd0);
         tick();
         @(negedge clk);
         chk("ct_busy_s_valid", {31'd0, s_if.valid}, 32'd1);
         chk("ct_grant_addr", s_if.addr, (k % 2 == 0) ? 32'h00000100 : 32'h00000200);
         tick();
         @(negedge clk);
         chk("ct_done_s_valid", {31'd0, s_if.valid}, 32'd0);
         chk("ct_done_state", {30'd0, dbg_state}, 32'd2);
         tick();
      end
      drive_m(0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive_m(1, 1'b0, 32'd0, 32'd0, 4'd0);
      s_if.ready = 1'b0;
      slave_echo = 1'b0;
      tick();

      // write pass-through by m1, slave answers in the third BUSY cycle
      drive_m(1, 1'b1, 32'h80000010, 32'h12345678, 4'b0011);
      tick();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            slave_rdata = 32'hCAFE0001;
            exp_q.push_back(mk_exp(1'b1, 32'hCAFE0001, 1'b0));
            s_if.ready = 1'b1;
         end
         @(negedge clk);
         chk("wr_s_valid", {31'd0, s_if.valid}, 32'd1);
         chk("wr_s_addr", s_if.addr, 32'h80000010);
         chk("wr_s_wdata", s_if.wdata, 32'h12345678);
         chk("wr_s_wen", {28'd0, s_if.wen}, 32'd3);
         tick();
      end
      s_if.ready = 1'b0;
      drive_m(1, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      chk("wr_done_s_valid", {31'd0, s_if.valid}, 32'd0);
      tick();

      // timeout: slave never answers, watchdog fires in the 8th BUSY cycle
      drive_m(0, 1'b1, 32'hFFFFFFFC, 32'd0, 4'd0);
      exp_q.push_back(mk_exp(1'b0, 32'hDEADBEEF, 1'b1));
      tick();
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         chk("to_s_valid", {31'd0, s_if.valid}, (i < 8) ? 32'd1 : 32'd0);
         if (i == 1) chk("to_wrap_addr", s_if.addr, 32'hFFFFFFFC);
         tick();
      end
      drive_m(0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      chk("to_done_state", {30'd0, dbg_state}, 32'd2);
      tick();
      tick();
      s_if.ready = 1'b1;
      slave_rdata = 32'h11111111;
      @(negedge clk);
      chk("late_ready_s_valid", {31'd0, s_if.valid}, 32'd0);
      tick();
      s_if.ready = 1'b0;

      // abort by m0, then a tie must go to m1 (m0 finished last)
      drive_m(0, 1'b1, 32'h80000040, 32'd0, 4'd0);
      tick();
      @(negedge clk);
      chk("ab_s_valid", {31'd0, s_if.valid}, 32'd1);
      tick();
      drive_m(0, 1'b0, 32'd0, 32'd0, 4'd0);
      @(negedge clk);
      chk("ab_s_valid_drop", {31'd0, s_if.valid}, 32'd0);
      tick();
      @(negedge clk);
      chk("ab_state_idle", {30'd0, dbg_state}, 32'd0);
      tick();
      drive_m(0, 1'b1, 32'h80000050, 32'd0, 4'd0);
      drive_m(1, 1'b1, 32'h80000060, 32'd0, 4'd0);
      tick();
      slave_rdata = 32'h0BADF00D;
      exp_q.push_back(mk_exp(1'b1, 32'h0BADF00D, 1'b0));
      s_if.ready = 1'b1;
      @(negedge clk);
      chk("ab_tie_addr", s_if.addr, 32'h80000060);
      tick();
      s_if.ready = 1'b0;
      drive_m(0, 1'b0, 32'd0, 32'd0, 4'd0);
      drive_m(1, 1'b0, 32'd0, 32'd0, 4'd0);
      tick();

      // asynchronous reset in the middle of BUSY
      drive_m(1, 1'b1, 32'h80000070, 32'd0, 4'd0);
      tick();
      slave_rdata = 32'h22222222;
      s_if.ready = 1'b1;
      #1;
      chk("ar_pre_s_valid", {31'd0, s_if.valid}, 32'd1);
      chk("ar_pre_m1_ready", {31'd0, m1_if.ready}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("ar_s_valid", {31'd0, s_if.valid}, 32'd0);
      chk("ar_ready", {30'd0, m0_if.ready, m1_if.ready}, 32'd0);
      chk("ar_s_addr", s_if.addr, 32'd0);
      chk("ar_m1_rdata", m1_if.rdata, 32'd0);
      s_if.ready = 1'b0;
      drive_m(1, 1'b0, 32'd0, 32'd0, 4'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      tick();
      @(negedge clk);
      chk("ar_state_idle", {30'd0, dbg_state}, 32'd0);
      tick();

      chk("exp_q_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/leiwand_rv32_mem_arbiter.md
Name: leiwand_rv32_mem_arbiter

Overview:
- Two-master, one-slave arbiter for the core memory bus (valid/ready/addr/wdata/rdata/wen).
- Shares one memory (simple_mem) between master 0 (leiwand_rv32_core) and master 1 (loader/debug DMA master).
- Round-robin grant, held for a whole transaction.
- Watchdog terminates transactions the slave never acknowledges and flags them with an error.

Parameters:
- XLEN, 32, address/data width.
- TIMEOUT_CYCLES, 64, BUSY cycles without s_ready before forced termination; minimum 2.
- ERR_DATA, 32'hDEADBEEF, rdata returned on timeout; zero-extended to XLEN.

Ports:
- clk  in  1  clock; everything samples on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_valid  in  1  master 0 request; held until m0_ready.
- m0_addr  in  XLEN  master 0 byte address.
- m0_wdata  in  XLEN  master 0 write data.
- m0_wen  in  4  master 0 byte write enables; 0 = read.
- m0_ready  out  1  master 0 completion pulse.
- m0_rdata  out  XLEN  master 0 read data; valid with m0_ready.
- m0_err  out  1  master 0 timeout flag; valid with m0_ready.
- m1_valid, m1_addr, m1_wdata, m1_wen, m1_ready, m1_rdata, m1_err: same as m0_* for master 1.
- s_valid  out  1  slave request.
- s_addr  out  XLEN  slave address.
- s_wdata  out  XLEN  slave write data.
- s_wen  out  4  slave byte write enables.
- s_ready  in  1  slave completion pulse.
- s_rdata  in  XLEN  slave read data.

Behaviour:
- Reset (reset_n=0, async):
  - state=IDLE, grant=0, last_grant=1 (so master 0 wins the first tie), timeout counter=0.
  - All outputs are 0: s_valid, s_addr, s_wdata, s_wen, m*_ready, m*_rdata, m*_err.
- States: IDLE, BUSY, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that master.
  - Both requesting: grant the master that is not last_grant.
  - On a grant: latch grant, clear counter, go to BUSY next cycle (one cycle of arbitration latency).
- BUSY:
  - s_valid = granted m_valid.
  - s_addr/s_wdata/s_wen are passed combinationally from the granted master.
  - The other master's inputs are ignored and its outputs held at 0.
- Normal completion (BUSY and s_ready=1):
  - Same cycle, combinational: granted m_ready=1, m_rdata=s_rdata, m_err=0.
  - Next cycle: last_grant=grant, state=DONE.
- Timeout (counter reaches TIMEOUT_CYCLES-1 in BUSY with s_ready=0):
  - Same cycle: granted m_ready=1, m_rdata=ERR_DATA, m_err=1, s_valid=0.
  - Next cycle: last_grant=grant, state=DONE.
  - A late s_ready arriving in DONE or IDLE is ignored and does not reach any master.
- Counter: increments every BUSY cycle and saturates. Per-transaction count is [0, TIMEOUT_CYCLES-1].
- Abort (granted m_valid drops in BUSY before completion):
  - s_valid drops the same cycle; no ready is produced.
  - Next state IDLE; last_grant is unchanged.
- DONE: exactly one cycle with all outputs 0, then IDLE. This gives the slave a guaranteed valid-low cycle between transactions.
- Back-to-back: a master that keeps valid high through DONE is re-arbitrated in IDLE. With both requesting, the grants alternate.
- Wrap-around: no address decode. Any address is forwarded unchanged, including 0xFFFFFFFC.
- All m*_ready, m*_rdata and m*_err are 0 outside a completion cycle.
- Reset mid-BUSY: outputs go to 0 immediately; any pending transaction is discarded without ready.

Test Plan:
- Single read: m0 reads 0x80000000, slave readies after 2 cycles with 0x00000297 -> s_valid goes high 1 cycle after m0_valid; m0_ready=1 and m0_rdata=0x00000297 in the s_ready cycle; m0_err=0; m1 outputs stay 0.
- Contention: m0 and m1 both valid from reset release, zero-wait slave -> grant order m0, m1, m0, m1; each completion is followed by one DONE cycle with s_valid=0.
- Write pass-through: m1 writes 0x12345678 to 0x80000010 with wen=4'b0011 -> s_wen=4'b0011, s_addr=0x80000010, s_wdata=0x12345678 for the whole BUSY period; m1_ready pulses once.
- Timeout: TIMEOUT_CYCLES=8, slave never readies -> m0_ready=1, m0_err=1, m0_rdata=0xDEADBEEF in the 8th BUSY cycle; a late s_ready 2 cycles later is ignored.
- Abort and async reset:
  - m0 drops valid during BUSY -> no m0_ready; the next tie is still won by m1 if last_grant was m0.
  - Assert reset_n=0 between clock edges during BUSY -> s_valid and all ready outputs are 0 before the next edge.
